prod_accum: RTL and testbench
=============================

Name: prod_accum

Overview:
- Downstream stage of the 4-bit combinational multiplier. Consumes its 8-bit product stream through a valid/ready handshake.
- Sums a programmable number of products into one wide accumulator, then presents the block result on a valid/ready output.
- Used for dot-product / multiply-accumulate sequences built on the multiplier.

Parameters:
- ACC_W, 16, accumulator and result width in bits; must be >= 8.
- LEN_W, 4, width of the block-length input. Up to 2^LEN_W - 1 products per block.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- clr  input  1  synchronous abort/clear of the current block
- len  input  LEN_W  number of products per block; sampled at the first accept of each block
- prod  input  8  product from the multiplier (P)
- in_valid  input  1  prod is valid
- in_ready  output  1  block can accept prod this cycle
- acc_out  output  ACC_W  block sum
- ovf  output  1  block sum exceeded ACC_W bits; qualified by out_valid
- out_valid  output  1  acc_out/ovf valid
- out_ready  input  1  consumer accepts result

Behaviour:
- Reset (async, rst=1):
  - state=ACC; acc=0; cnt=0; len_q=0; ovf=0.
  - out_valid=0, in_ready=0 while rst is high; in_ready=1 from the first clock after release.
  - acc_out=0.
- State ACC:
  - in_ready=1, out_valid=0.
  - Accept occurs on a cycle with in_valid & in_ready.
  - On an accept: acc <= acc + zero-extended prod, computed in ACC_W+1 bits.
  - A carry out of bit ACC_W-1 sets the sticky ovf.
  - cnt increments on each accept.
  - On an accept with cnt==0: len_q <= len, and len is used for the terminal check that same cycle. len=0 is treated as 1.
  - When the accept is the last of the block (cnt == effective_len-1): go to HOLD; cnt <= 0.
- State HOLD:
  - in_ready=0, out_valid=1.
  - acc_out and ovf are stable until handshake.
  - On out_valid & out_ready: acc <= 0, ovf <= 0, return to ACC.
  - in_ready rises the next cycle. There is no same-cycle accept of a new product on the output handshake cycle.
- Latency:
  - out_valid asserts the cycle after the final product is accepted.
  - acc_out includes that final product.
  - Minimum block throughput: len + 1 cycles with out_ready held high.
- acc_out is the registered accumulator, driven directly (no output mux).
- clr:
  - Highest priority after rst. In any state: acc=0, cnt=0, ovf=0, state=ACC, out_valid=0.
  - Any simultaneous input accept or output handshake is discarded.
- len changes mid-block are ignored; len_q holds until the next block starts.
- prod is held don't-care when in_valid=0; acc does not change.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Optional Feature:
- Macro PROD_ACCUM_SATURATE_EN.
- Defined:
  - On an accept that would exceed 2^ACC_W-1, acc clamps to all ones and ovf sets.
  - Further accepts in the block leave acc at all ones.
- Undefined:
  - acc wraps modulo 2^ACC_W.
  - ovf still flags the first carry out, and stays sticky for the block.

Test Plan:
- Reset then len=4, four accepts of prod=225 (15*15), out_ready=1 -> out_valid one cycle after the 4th accept; acc_out=900 (0x0384), ovf=0; in_ready=1 the cycle after the handshake.
- Block complete, out_ready=0 for 3 cycles, in_valid=1 with prod=7 -> in_ready=0, acc_out stays 900, no accept. Then out_ready=1 -> next block starts with acc=0 and the first accepted prod=7.
- ACC_W=10, len=5, five prod=225 (sum 1125):
  - Without macro -> acc_out=101, ovf=1.
  - With PROD_ACCUM_SATURATE_EN -> acc_out=1023, ovf=1.
- len=3; accepts 10, 20. Assert clr on the same cycle as a third valid prod=30 -> acc=0, cnt=0, no out_valid. Then three prods 1,2,3 -> acc_out=6.
- len=0, single prod=81 -> out_valid next cycle, acc_out=81. Changing len to 2 mid-HOLD does not affect the current result; the next block uses len=2.
- Assert rst asynchronously mid-block (between clock edges) after 2 of 4 accepts -> acc_out=0, out_valid=0, in_ready=0 immediately. After release, a fresh 4-product block of 1s -> acc_out=4.

Source files
------------

// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - sums a block of 8-bit multiplier products into an ACC_W-bit result
// Optional PROD_ACCUM_SATURATE_EN: clamp the sum at all ones instead of wrapping.
module prod_accum #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       prod,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [0:0]       ST_ACC  = 1'b0;
  localparam logic [0:0]       ST_HOLD = 1'b1;
  localparam logic [LEN_W-1:0] ONE     = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_cur;
  logic [LEN_W-1:0] last_idx;
  logic [ACC_W:0]   sum;
  logic             ovf_q;
  logic             rdy_q;
  logic             accept;
  logic             last;
  logic             take;

  // rdy_q is a register so in_ready never depends combinationally on in_valid
  assign accept   = in_valid & rdy_q;
  assign take     = (state == ST_HOLD) & out_ready;
  assign len_cur  = (cnt == '0) ? len : len_q;
  assign last_idx = (len_cur == '0) ? '0 : len_cur - ONE;
  assign last     = (cnt == last_idx);
  assign sum      = {1'b0, acc} + {{(ACC_W-7){1'b0}}, prod};

`ifdef PROD_ACCUM_SATURATE_EN
  assign acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ACC;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
      rdy_q <= 1'b0;
    end else if (clr) begin
      state <= ST_ACC;
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      case (state)
        ST_ACC: begin
          rdy_q <= 1'b1;
          if (accept) begin
            acc   <= acc_nxt;
            ovf_q <= ovf_q | sum[ACC_W];
            if (cnt == '0) len_q <= len;
            if (last) begin
              state <= ST_HOLD;
              cnt   <= '0;
              rdy_q <= 1'b0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        ST_HOLD: begin
          if (take) begin
            state <= ST_ACC;
            acc   <= '0;
            ovf_q <= 1'b0;
            rdy_q <= 1'b1;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state == ST_HOLD);
  assign acc_out   = acc;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// tb/tb_prod_accum.sv - self-checking bench for prod_accum
module tb_prod_accum;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, out_ready;
  logic [3:0]  len;
  logic [7:0]  prod;
  logic        in_ready, ovf, out_valid;
  logic [15:0] acc_out;

  logic        w_clr, w_in_valid, w_out_ready, w_in_ready, w_ovf, w_out_valid;
  logic [3:0]  w_len;
  logic [7:0]  w_prod;
  logic [9:0]  w_acc_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  len;
    int          n;
    logic [7:0]  p0;
    logic [7:0]  step;
    logic [15:0] exp_acc;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [15:0] acc;
    logic        ovf;
  } res_t;

  vec_t vecs[6];
  res_t sb[$];

  prod_accum #(.ACC_W(16), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .len(len), .prod(prod),
    .in_valid(in_valid), .in_ready(in_ready), .acc_out(acc_out),
    .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  prod_accum #(.ACC_W(10), .LEN_W(4)) dut_w (
    .clk(clk), .rst(rst), .clr(w_clr), .len(w_len), .prod(w_prod),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .acc_out(w_acc_out),
    .ovf(w_ovf), .out_valid(w_out_valid), .out_ready(w_out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: a handshake happens on the next edge when both are high here.
  always @(negedge clk) begin
    res_t r;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        r = sb.pop_front();
        check("sb_acc_out", {16'd0, acc_out}, {16'd0, r.acc});
        check("sb_ovf", {31'd0, ovf}, {31'd0, r.ovf});
      end
    end
  end

  task automatic send(input logic [7:0] p);
    int t;
    t = 0;
    prod     = p;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    prod     = 8'd0;
  endtask

  task automatic run_block(input logic [3:0] l, input int n, input logic [7:0] p0,
                           input logic [7:0] step, input logic [15:0] ea, input logic eo);
    res_t r;
    logic [7:0] p;
    len   = l;
    r.acc = ea;
    r.ovf = eo;
    sb.push_back(r);
    p = p0;
    for (int i = 0; i < n; i++) begin
      send(p);
      p = p + step;
    end
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    if (out_ready) begin
      tick();
      check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
      check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [9:0] w_exp;
    vecs[0] = '{4'd4,  4,  8'd225, 8'd0,   16'd900,  1'b0};
    vecs[1] = '{4'd0,  1,  8'd81,  8'd0,   16'd81,   1'b0};
    vecs[2] = '{4'd3,  3,  8'd1,   8'd1,   16'd6,    1'b0};
    vecs[3] = '{4'd15, 15, 8'd255, 8'd0,   16'd3825, 1'b0};
    vecs[4] = '{4'd1,  1,  8'd0,   8'd0,   16'd0,    1'b0};
    vecs[5] = '{4'd2,  2,  8'd100, 8'd100, 16'd300,  1'b0};

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; prod = 8'd0; len = 4'd0; out_ready = 1'b1;
    w_clr = 1'b0; w_in_valid = 1'b0; w_prod = 8'd0; w_len = 4'd0; w_out_ready = 1'b1;

    #3;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_acc_out", {16'd0, acc_out}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("release_in_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    check("first_clk_in_ready", {31'd0, in_ready}, 32'd1);

    // Narrow accumulator: 5 x 225 = 1125 overflows 10 bits
    w_len = 4'd5; w_prod = 8'd225; w_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("w_in_ready", {31'd0, w_in_ready}, 32'd1);
      tick();
    end
    w_in_valid = 1'b0;
`ifdef PROD_ACCUM_SATURATE_EN
    w_exp = 10'd1023;
`else
    w_exp = 10'd101;
`endif
    check("w_out_valid", {31'd0, w_out_valid}, 32'd1);
    check("w_acc_out", {22'd0, w_acc_out}, {22'd0, w_exp});
    check("w_ovf", {31'd0, w_ovf}, 32'd1);
    tick();
    check("w_out_valid_cleared", {31'd0, w_out_valid}, 32'd0);
    check("w_ovf_cleared", {31'd0, w_ovf}, 32'd0);

    for (int v = 0; v < 6; v++)
      run_block(vecs[v].len, vecs[v].n, vecs[v].p0, vecs[v].step, vecs[v].exp_acc, vecs[v].exp_ovf);

    // Output backpressure with a pending input
    out_ready = 1'b0;
    run_block(4'd4, 4, 8'd225, 8'd0, 16'd900, 1'b0);
    len = 4'd1; prod = 8'd7; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_acc_out", {16'd0, acc_out}, 32'd900);
    end
    out_ready = 1'b1;
    tick();
    check("bp_hs_acc_clear", {16'd0, acc_out}, 32'd0);
    check("bp_hs_in_ready", {31'd0, in_ready}, 32'd1);
    sb.push_back('{16'd7, 1'b0});
    tick();
    in_valid = 1'b0;
    check("bp_next_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_acc", {16'd0, acc_out}, 32'd7);
    tick();

    // Clear collides with an input accept
    len = 4'd3;
    send(8'd10);
    send(8'd20);
    prod = 8'd30; in_valid = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check("clr_acc_out", {16'd0, acc_out}, 32'd0);
    check("clr_out_valid", {31'd0, out_valid}, 32'd0);
    run_block(4'd3, 3, 8'd1, 8'd1, 16'd6, 1'b0);

    // len=0 acts as 1; changing len during HOLD only affects the next block
    out_ready = 1'b0;
    run_block(4'd0, 1, 8'd81, 8'd0, 16'd81, 1'b0);
    len = 4'd2;
    tick();
    tick();
    check("len_hold_acc", {16'd0, acc_out}, 32'd81);
    check("len_hold_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    run_block(4'd2, 2, 8'd5, 8'd1, 16'd11, 1'b0);

    // Asynchronous reset mid-block
    len = 4'd4;
    send(8'd1);
    send(8'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_acc_out", {16'd0, acc_out}, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_block(4'd4, 4, 8'd1, 8'd0, 16'd4, 1'b0);

    repeat (3) tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
